// File: rtl/sargantana_icache_pkg.sv
// Shared types and default sizing for the icache iFill arbiter slice.
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_LINE_ADDR_W = 34;
  localparam int unsigned ICACHE_WAY_W       = 2;
  localparam int unsigned ICACHE_PF_DEPTH    = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_REQ   = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DRAIN = 2'd3
  } ifill_arb_state_t;

  typedef enum logic {
    OWN_DMD = 1'b0,
    OWN_PF  = 1'b1
  } ifill_owner_t;

endpackage

// File: rtl/sargantana_icache_ifill_arbiter_if.sv
// Upper-level iFill port: one outstanding line request and its single-beat response.
interface sargantana_icache_ifill_arbiter_if
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned LINE_ADDR_W = ICACHE_LINE_ADDR_W,
  parameter int unsigned WAY_W       = ICACHE_WAY_W
) ();

  logic                   req_valid;
  logic [LINE_ADDR_W-1:0] req_paddr;
  logic [WAY_W-1:0]       req_way;
  logic                   ack;
  logic                   resp_valid;

  modport master (
    output req_valid, req_paddr, req_way,
    input  ack, resp_valid
  );

  modport slave (
    input  req_valid, req_paddr, req_way,
    output ack, resp_valid
  );

endinterface

// File: rtl/sargantana_icache_pf_fifo.sv
// Prefetch request FIFO (line address + victim way) with synchronous flush and occupancy count.
module sargantana_icache_pf_fifo
  import sargantana_icache_pkg::*;
#(
  parameter  int unsigned LINE_ADDR_W = ICACHE_LINE_ADDR_W,
  parameter  int unsigned WAY_W       = ICACHE_WAY_W,
  parameter  int unsigned DEPTH       = ICACHE_PF_DEPTH,
  localparam int unsigned PTR_W       = $clog2(DEPTH),
  localparam int unsigned CNT_W       = PTR_W + 1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [LINE_ADDR_W-1:0] push_paddr_i,
  input  logic [WAY_W-1:0]       push_way_i,
  input  logic                   pop_i,
  output logic [LINE_ADDR_W-1:0] head_paddr_o,
  output logic [WAY_W-1:0]       head_way_o,
  output logic [CNT_W-1:0]       count_o
);

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] paddr;
    logic [WAY_W-1:0]       way;
  } pf_entry_t;

  pf_entry_t        mem_q [DEPTH];
  pf_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Callers guarantee no push at full and no pop when empty; flush overrides both.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = '{paddr: push_paddr_i, way: push_way_i};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_paddr_o = mem_q[rd_ptr_q].paddr;
  assign head_way_o   = mem_q[rd_ptr_q].way;
  assign count_o      = count_q;

endmodule

// File: rtl/sargantana_icache_ifill_arbiter.sv
// Single owner of the icache iFill port: demand misses beat next-line prefetches, one fill in flight,
// with kill/flush tracking and routing of each response to demand refill, prefetch fill or drop.
module sargantana_icache_ifill_arbiter
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned LINE_ADDR_W = ICACHE_LINE_ADDR_W,
  parameter int unsigned WAY_W       = ICACHE_WAY_W,
  parameter int unsigned PF_DEPTH    = ICACHE_PF_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   dmd_valid_i,
  input  logic [LINE_ADDR_W-1:0] dmd_paddr_i,
  input  logic [WAY_W-1:0]       dmd_way_i,
  input  logic                   dmd_kill_i,
  input  logic                   pf_valid_i,
  input  logic [LINE_ADDR_W-1:0] pf_paddr_i,
  input  logic [WAY_W-1:0]       pf_way_i,
  output logic                   pf_ready_o,
  sargantana_icache_ifill_arbiter_if.master ifill,
  output logic                   dmd_fill_o,
  output logic                   pf_fill_o,
  output logic                   fill_drop_o,
  output logic [WAY_W-1:0]       fill_way_o,
  output logic                   busy_o
);

  localparam int unsigned CNT_W = $clog2(PF_DEPTH) + 1;

  ifill_arb_state_t       state_q, state_d;
  ifill_owner_t           owner_q, owner_d;
  logic [LINE_ADDR_W-1:0] req_paddr_q, req_paddr_d;
  logic [WAY_W-1:0]       req_way_q, req_way_d;

  logic                   pf_push, pf_pop, pf_empty;
  logic [CNT_W-1:0]       pf_count;
  logic [LINE_ADDR_W-1:0] pf_head_paddr;
  logic [WAY_W-1:0]       pf_head_way;
  logic                   abort;

  // A kill only concerns the demand; a prefetch in flight survives it.
  assign abort = flush_i | (dmd_kill_i & (owner_q == OWN_DMD));

  assign pf_empty   = (pf_count == '0);
  assign pf_ready_o = (pf_count < CNT_W'(PF_DEPTH));
  assign pf_push    = pf_valid_i & pf_ready_o & ~flush_i
                    & ~((state_q != ARB_IDLE) & (pf_paddr_i == req_paddr_q));

  sargantana_icache_pf_fifo #(
    .LINE_ADDR_W (LINE_ADDR_W),
    .WAY_W       (WAY_W),
    .DEPTH       (PF_DEPTH)
  ) u_pf_fifo (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .flush_i      (flush_i),
    .push_i       (pf_push),
    .push_paddr_i (pf_paddr_i),
    .push_way_i   (pf_way_i),
    .pop_i        (pf_pop),
    .head_paddr_o (pf_head_paddr),
    .head_way_o   (pf_head_way),
    .count_o      (pf_count)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_DMD;
      req_paddr_q <= '0;
      req_way_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      req_paddr_q <= req_paddr_d;
      req_way_q   <= req_way_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_paddr_d = req_paddr_q;
    req_way_d   = req_way_q;
    pf_pop      = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (dmd_valid_i && !dmd_kill_i && !flush_i) begin
          state_d     = ARB_REQ;
          owner_d     = OWN_DMD;
          req_paddr_d = dmd_paddr_i;
          req_way_d   = dmd_way_i;
        end else if (!pf_empty && !dmd_valid_i && !flush_i) begin
          pf_pop      = 1'b1;
          state_d     = ARB_REQ;
          owner_d     = OWN_PF;
          req_paddr_d = pf_head_paddr;
          req_way_d   = pf_head_way;
        end
      end
      ARB_REQ: begin
        // Once accepted the upper level will respond, so an abort must drain it.
        if (ifill.ack) begin
          state_d = abort ? ARB_DRAIN : ARB_WAIT;
        end else if (abort) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        if (ifill.resp_valid) begin
          state_d = ARB_IDLE;
        end else if (abort) begin
          state_d = ARB_DRAIN;
        end else if (owner_q == OWN_PF && dmd_valid_i && !dmd_kill_i
                     && dmd_paddr_i == req_paddr_q) begin
          owner_d = OWN_DMD;
        end
      end
      ARB_DRAIN: begin
        if (ifill.resp_valid) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ifill.req_valid = (state_q == ARB_REQ);
    ifill.req_paddr = req_paddr_q;
    ifill.req_way   = req_way_q;
    busy_o          = (state_q != ARB_IDLE);
    dmd_fill_o      = ifill.resp_valid & (state_q == ARB_WAIT) & ~abort & (owner_q == OWN_DMD);
    pf_fill_o       = ifill.resp_valid & (state_q == ARB_WAIT) & ~abort & (owner_q == OWN_PF);
    fill_drop_o     = ifill.resp_valid
                    & ((state_q == ARB_DRAIN) | ((state_q == ARB_WAIT) & abort));
    fill_way_o      = (dmd_fill_o | pf_fill_o) ? req_way_q : '0;
  end

endmodule

// File: tb/tb_sargantana_icache_ifill_arbiter.sv
// Bench for the iFill arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_sargantana_icache_ifill_arbiter;
  import sargantana_icache_pkg::*;

  localparam int unsigned AW    = 34;
  localparam int unsigned WW    = 2;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic          dv;
    logic [AW-1:0] dp;
    logic [WW-1:0] dw;
    logic          dk;
    logic          pv;
    logic [AW-1:0] pp;
    logic [WW-1:0] pw;
    logic          ak;
    logic          rs;
    logic          fl;
  } stim_t;

  typedef struct packed {
    logic [AW-1:0] paddr;
    logic [WW-1:0] way;
  } line_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush_i, dmd_valid_i, dmd_kill_i, pf_valid_i;
  logic [AW-1:0] dmd_paddr_i, pf_paddr_i;
  logic [WW-1:0] dmd_way_i, pf_way_i, fill_way_o;
  logic          pf_ready_o, dmd_fill_o, pf_fill_o, fill_drop_o, busy_o;

  sargantana_icache_ifill_arbiter_if #(.LINE_ADDR_W(AW), .WAY_W(WW)) ifill ();

  sargantana_icache_ifill_arbiter #(
    .LINE_ADDR_W (AW),
    .WAY_W       (WW),
    .PF_DEPTH    (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .flush_i     (flush_i),
    .dmd_valid_i (dmd_valid_i),
    .dmd_paddr_i (dmd_paddr_i),
    .dmd_way_i   (dmd_way_i),
    .dmd_kill_i  (dmd_kill_i),
    .pf_valid_i  (pf_valid_i),
    .pf_paddr_i  (pf_paddr_i),
    .pf_way_i    (pf_way_i),
    .pf_ready_o  (pf_ready_o),
    .ifill       (ifill),
    .dmd_fill_o  (dmd_fill_o),
    .pf_fill_o   (pf_fill_o),
    .fill_drop_o (fill_drop_o),
    .fill_way_o  (fill_way_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference: at most one fill record plus a queue of pending prefetches.
  bit            m_busy, m_acked, m_dead, m_dmd;
  logic [AW-1:0] m_paddr;
  logic [WW-1:0] m_way;
  line_t         m_q[$];

  logic          last_req_valid, last_busy, last_ready, last_dfill, last_pfill, last_drop;
  logic [AW-1:0] last_req_paddr;
  logic [WW-1:0] last_way;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_acked = 0; m_dead = 0; m_dmd = 0;
    m_paddr = '0; m_way = '0;
    m_q.delete();
  endtask

  task automatic model_start(input logic [AW-1:0] a, input logic [WW-1:0] w, input bit is_dmd);
    m_busy = 1; m_acked = 0; m_dead = 0; m_dmd = is_dmd;
    m_paddr = a; m_way = w;
  endtask

  task automatic drive(input stim_t s);
    dmd_valid_i = s.dv; dmd_paddr_i = s.dp; dmd_way_i = s.dw; dmd_kill_i = s.dk;
    pf_valid_i  = s.pv; pf_paddr_i  = s.pp; pf_way_i  = s.pw;
    ifill.ack   = s.ak; ifill.resp_valid = s.rs; flush_i = s.fl;
  endtask

  // One clock cycle: drive at posedge+1, compare at posedge+2, advance model, wait for next edge.
  task automatic step(input stim_t s);
    bit    e_req, e_ready, abort, fire, e_drop, e_dfill, e_pfill, push_ok;
    logic [WW-1:0] e_way;
    line_t hd;
    drive(s);
    #1;
    e_req   = m_busy && !m_acked;
    e_ready = (m_q.size() < DEPTH);
    abort   = s.fl || (s.dk && m_dmd);
    fire    = s.rs && m_busy && m_acked;
    e_drop  = fire && (m_dead || abort);
    e_dfill = fire && !e_drop && m_dmd;
    e_pfill = fire && !e_drop && !m_dmd;
    e_way   = (e_dfill || e_pfill) ? m_way : '0;
    check("req_valid", ifill.req_valid, e_req);
    check("busy", busy_o, m_busy);
    check("pf_ready", pf_ready_o, e_ready);
    check("dmd_fill", dmd_fill_o, e_dfill);
    check("pf_fill", pf_fill_o, e_pfill);
    check("fill_drop", fill_drop_o, e_drop);
    check("fill_way", fill_way_o, e_way);
    if (e_req) begin
      check("req_paddr", ifill.req_paddr, m_paddr);
      check("req_way", ifill.req_way, m_way);
    end
    last_req_valid = ifill.req_valid; last_req_paddr = ifill.req_paddr;
    last_busy = busy_o; last_ready = pf_ready_o;
    last_dfill = dmd_fill_o; last_pfill = pf_fill_o; last_drop = fill_drop_o; last_way = fill_way_o;

    push_ok = s.pv && e_ready && !s.fl && !(m_busy && s.pp == m_paddr);
    if (m_busy && m_acked) begin
      if (s.rs) m_busy = 0;
      else if (!m_dead) begin
        if (abort) m_dead = 1;
        else if (!m_dmd && s.dv && !s.dk && s.dp == m_paddr) m_dmd = 1;
      end
    end else if (m_busy) begin
      if (s.ak) begin
        m_acked = 1;
        m_dead  = abort;
      end else if (abort) m_busy = 0;
    end else begin
      if (s.dv && !s.dk && !s.fl) model_start(s.dp, s.dw, 1);
      else if (m_q.size() > 0 && !s.dv && !s.fl) begin
        hd = m_q.pop_front();
        model_start(hd.paddr, hd.way, 0);
      end
    end
    if (s.fl) m_q.delete();
    else if (push_ok) m_q.push_back('{paddr: s.pp, way: s.pw});
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t nop();
    return '0;
  endfunction

  function automatic stim_t dmd(input logic [AW-1:0] a, input logic [WW-1:0] w);
    stim_t s = '0;
    s.dv = 1; s.dp = a; s.dw = w;
    return s;
  endfunction

  function automatic stim_t pf(input logic [AW-1:0] a, input logic [WW-1:0] w);
    stim_t s = '0;
    s.pv = 1; s.pp = a; s.pw = w;
    return s;
  endfunction

  function automatic stim_t ack();
    stim_t s = '0;
    s.ak = 1;
    return s;
  endfunction

  function automatic stim_t resp();
    stim_t s = '0;
    s.rs = 1;
    return s;
  endfunction

  task automatic apply_reset();
    rstn = 1'b0;
    drive(nop());
    model_clear();
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_req_valid", ifill.req_valid, 1'b0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    rstn = 1'b0;
    drive(nop());
    model_clear();
    @(posedge clk);
    #1;
    apply_reset();
    step(nop());
    check("reset_ready", last_ready, 1'b1);

    // Demand 0x1234 way 2: ack at +2, response at +6
    step(dmd(34'h1234, 2'd2));
    step(nop());   check("d1_valid_c1", last_req_valid, 1'b1);
    step(ack());   check("d1_valid_c2", last_req_valid, 1'b1);
    step(nop());   check("d1_valid_c3", last_req_valid, 1'b0);
    step(nop());
    step(nop());
    step(resp());  check("d1_dmd_fill", last_dfill, 1'b1); check("d1_way", last_way, 2'd2);
    step(nop());   check("d1_idle", last_busy, 1'b0);

    // Prefetch FIFO saturates while a demand is in flight
    step(dmd(34'h40, 2'd0));
    step(pf(34'h100, 2'd1));
    step(pf(34'h101, 2'd3));
    step(pf(34'h102, 2'd0)); check("pf_full_ready", last_ready, 1'b0);
    step(ack());
    step(resp());
    step(nop());
    step(ack());   check("pf_first", last_req_paddr, 34'h100);
    step(resp());  check("pf_first_fill", last_pfill, 1'b1);
    step(nop());
    step(ack());   check("pf_second", last_req_paddr, 34'h101);
    step(resp());

    // Demand hitting the in-flight prefetch line is promoted
    step(pf(34'h200, 2'd1));
    step(nop());
    step(ack());   check("promo_req", last_req_paddr, 34'h200);
    step(dmd(34'h200, 2'd1)); check("promo_no_req", last_req_valid, 1'b0);
    s = dmd(34'h200, 2'd1); s.rs = 1;
    step(s);       check("promo_dfill", last_dfill, 1'b1); check("promo_no_pfill", last_pfill, 1'b0);
    step(nop());   check("promo_idle", last_req_valid, 1'b0);

    // Kill in WAIT drains; next demand accepted right after
    step(dmd(34'h300, 2'd3));
    step(ack());
    s = nop(); s.dk = 1;
    step(s);
    step(nop());
    s = dmd(34'h301, 2'd0); s.rs = 1;
    step(s);       check("kill_drop", last_drop, 1'b1);
    step(dmd(34'h301, 2'd0));
    step(ack());   check("kill_next_req", last_req_valid, 1'b1);
    step(resp());

    // Demand beats a queued prefetch in IDLE
    step(dmd(34'h500, 2'd1));
    step(pf(34'h501, 2'd2));
    step(ack());
    step(resp());
    step(dmd(34'h502, 2'd3));
    step(ack());   check("prio_dmd", last_req_paddr, 34'h502);
    step(resp());
    step(nop());
    step(ack());   check("prio_pf", last_req_paddr, 34'h501);
    step(resp());

    // Flush in REQ with two prefetches queued
    step(dmd(34'h600, 2'd0));
    step(pf(34'h601, 2'd1));
    step(pf(34'h602, 2'd2));
    s = nop(); s.fl = 1;
    step(s);
    step(nop());   check("flush_valid", last_req_valid, 1'b0); check("flush_ready", last_ready, 1'b1);
    step(nop());   check("flush_no_pop", last_req_valid, 1'b0);

    // Random traffic over a small address window to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      s.dv = ($urandom_range(0, 99) < 30);
      s.dp = 34'h100 + 34'($urandom_range(0, 5));
      s.dw = 2'($urandom_range(0, 3));
      s.dk = ($urandom_range(0, 99) < 5);
      s.pv = ($urandom_range(0, 99) < 35);
      s.pp = 34'h100 + 34'($urandom_range(0, 5));
      s.pw = 2'($urandom_range(0, 3));
      s.ak = ($urandom_range(0, 99) < 40);
      s.rs = ($urandom_range(0, 99) < 25);
      s.fl = ($urandom_range(0, 99) < 3);
      step(s);
    end

    // Async reset mid-fill; stray response afterwards is ignored
    apply_reset();
    step(dmd(34'h700, 2'd1));
    step(ack());
    #2;
    rstn = 1'b0;
    drive(nop());
    model_clear();
    #1;
    check("amid_busy", busy_o, 1'b0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    step(resp());  check("stray_drop", last_drop, 1'b0); check("stray_dfill", last_dfill, 1'b0);
    step(nop());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
